// File: rtl/ring_counter_multi.sv
// WIDTH-bit one-hot ring / Johnson counter with direction, enable, prescaler,
// parallel load, illegal-state self-correction and a registered wrap pulse.
module ring_counter_multi #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Mode,
  input  logic             Dir,
  input  logic [DIV_W-1:0] Div,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  output logic [WIDTH-1:0] Count_out,
  output logic [WIDTH-1:0] Count_oeb,
  output logic             Wrap,
  output logic             Illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             mode_q;
  logic [DIV_W-1:0] pre;
  logic             tick;
  logic [WIDTH-1:0] seed_cur;
  logic [WIDTH-1:0] seed_new;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    ones_count;
  logic [CW-1:0]    diff_count;

  // >= rather than == so lowering Div mid-count cannot strand the prescaler
  assign tick     = Enable && (pre >= Div);
  assign seed_cur = mode_q ? '0 : WIDTH'(1);
  assign seed_new = Mode   ? '0 : WIDTH'(1);

  // Johnson legality: adjacent-bit transitions around the ring must be 0 or 2
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff[gi] = Count_out[gi] ^ Count_out[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  always_comb begin
    ones_count = '0;
    diff_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_count = ones_count + CW'(Count_out[i]);
      diff_count = diff_count + CW'(diff[i]);
    end
  end

  always_comb begin
    if (mode_q)
      Illegal = !((diff_count == CW'(0)) || (diff_count == CW'(2)));
    else
      Illegal = (ones_count != CW'(1));
  end

  always_comb begin
    case ({mode_q, Dir})
      2'b00:   stepped = {Count_out[WIDTH-2:0], Count_out[WIDTH-1]};
      2'b01:   stepped = {Count_out[0], Count_out[WIDTH-1:1]};
      2'b10:   stepped = {Count_out[WIDTH-2:0], ~Count_out[WIDTH-1]};
      default: stepped = {~Count_out[0], Count_out[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Count_out <= WIDTH'(1);
      Count_oeb <= '1;
      mode_q    <= 1'b0;
      pre       <= '0;
      Wrap      <= 1'b0;
    end else begin
      Count_oeb <= '0;
      if (Mode != mode_q) begin
        mode_q    <= Mode;
        Count_out <= seed_new;
        pre       <= '0;
        Wrap      <= 1'b0;
      end else if (Load) begin
        Count_out <= Load_val;
        pre       <= '0;
        Wrap      <= 1'b0;
      end else if (tick && Illegal) begin
        Count_out <= seed_cur;
        pre       <= '0;
        Wrap      <= 1'b0;
      end else if (tick) begin
        Count_out <= stepped;
        pre       <= '0;
        Wrap      <= (stepped == seed_cur);
      end else begin
        if (Enable)
          pre <= pre + 1'b1;
        Wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_multi.sv
// Scoreboard bench for ring_counter_multi (WIDTH=4): expected state is queued
// as each cycle's stimulus is driven and popped after the following clock edge.
module tb_ring_counter_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic       dir;
  logic [7:0] div;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic [3:0] count_oeb;
  logic       wrap;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cnt;
    logic       wr;
    logic       il;
    logic [3:0] oeb;
  } exp_t;

  exp_t sb_q[$];

  ring_counter_multi #(.WIDTH(4), .DIV_W(8)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .Enable    (enable),
    .Mode      (mode),
    .Dir       (dir),
    .Div       (div),
    .Load      (load),
    .Load_val  (load_val),
    .Count_out (count_out),
    .Count_oeb (count_oeb),
    .Wrap      (wrap),
    .Illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push the expectation for the stimulus now on the pins, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [3:0] cnt, input logic wr, input logic il);
    exp_t e;
    e.cnt = cnt;
    e.wr  = wr;
    e.il  = il;
    e.oeb = 4'b0000;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_count"},   {28'd0, count_out}, {28'd0, e.cnt});
      check_val({tag, "_wrap"},    {31'd0, wrap},      {31'd0, e.wr});
      check_val({tag, "_illegal"}, {31'd0, illegal},   {31'd0, e.il});
      check_val({tag, "_oeb"},     {28'd0, count_oeb}, {28'd0, e.oeb});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] jseq [8];
    jseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; dir = 1'b0;
    div = 8'd0; load = 1'b0; load_val = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count",   {28'd0, count_out}, 32'h1);
    check_val("rst_oeb",     {28'd0, count_oeb}, 32'hf);
    check_val("rst_wrap",    {31'd0, wrap},      32'h0);
    check_val("rst_illegal", {31'd0, illegal},   32'h0);

    // ring, Div=0, Dir=0
    rst_n = 1'b1; enable = 1'b1;
    cyc("ring0", 4'b0010, 1'b0, 1'b0);
    cyc("ring1", 4'b0100, 1'b0, 1'b0);
    cyc("ring2", 4'b1000, 1'b0, 1'b0);
    cyc("ring3", 4'b0001, 1'b1, 1'b0);
    cyc("ring4", 4'b0010, 1'b0, 1'b0);

    // Johnson, Div=0, Dir=0
    mode = 1'b1;
    cyc("jseed", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("john%0d", i), jseq[i], (i == 7), 1'b0);

    // ring, Div=2, enable freeze, direction change
    mode = 1'b0; div = 8'd2;
    cyc("div_seed", 4'b0001, 1'b0, 1'b0);
    cyc("div_a",    4'b0001, 1'b0, 1'b0);
    cyc("div_b",    4'b0001, 1'b0, 1'b0);
    cyc("div_c",    4'b0010, 1'b0, 1'b0);
    cyc("div_d",    4'b0010, 1'b0, 1'b0);
    cyc("div_e",    4'b0010, 1'b0, 1'b0);
    cyc("div_f",    4'b0100, 1'b0, 1'b0);
    dir = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc($sformatf("hold%0d", i), 4'b0100, 1'b0, 1'b0);
    enable = 1'b1;
    cyc("resume_a", 4'b0100, 1'b0, 1'b0);
    cyc("resume_b", 4'b0100, 1'b0, 1'b0);
    cyc("dir_right", 4'b0010, 1'b0, 1'b0);

    // illegal load and self-correction, ring then Johnson
    dir = 1'b0; div = 8'd0;
    load = 1'b1; load_val = 4'b0110;
    cyc("ld_ring", 4'b0110, 1'b0, 1'b1);
    load = 1'b0;
    cyc("fix_ring", 4'b0001, 1'b0, 1'b0);
    cyc("post_fix", 4'b0010, 1'b0, 1'b0);
    mode = 1'b1;
    cyc("to_john", 4'b0000, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0101;
    cyc("ld_john", 4'b0101, 1'b0, 1'b1);
    load = 1'b0;
    cyc("fix_john", 4'b0000, 1'b0, 1'b0);

    // mode change beats a simultaneous load and clears the prescaler
    mode = 1'b0; div = 8'd1;
    cyc("m5_seed", 4'b0001, 1'b0, 1'b0);
    cyc("m5_a",    4'b0001, 1'b0, 1'b0);
    cyc("m5_b",    4'b0010, 1'b0, 1'b0);
    cyc("m5_c",    4'b0010, 1'b0, 1'b0);
    cyc("m5_d",    4'b0100, 1'b0, 1'b0);
    cyc("m5_e",    4'b0100, 1'b0, 1'b0);
    mode = 1'b1; load = 1'b1; load_val = 4'b1111;
    cyc("mode_wins", 4'b0000, 1'b0, 1'b0);
    load = 1'b0;
    cyc("pre_clr",   4'b0000, 1'b0, 1'b0);
    cyc("m5_step",   4'b0001, 1'b0, 1'b0);

    // asynchronous reset mid-cycle at 1000, Div=5
    mode = 1'b0;
    cyc("r6_seed", 4'b0001, 1'b0, 1'b0);
    div = 8'd5; load = 1'b1; load_val = 4'b1000;
    cyc("r6_load", 4'b1000, 1'b0, 1'b0);
    load = 1'b0;
    cyc("r6_a", 4'b1000, 1'b0, 1'b0);
    cyc("r6_b", 4'b1000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_count", {28'd0, count_out}, 32'h1);
    check_val("arst_oeb",   {28'd0, count_oeb}, 32'hf);
    check_val("arst_wrap",  {31'd0, wrap},      32'h0);
    @(posedge clk);
    #1;
    check_val("arst_hold", {28'd0, count_out}, 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc($sformatf("rel%0d", i), 4'b0001, 1'b0, 1'b0);
    cyc("rel_step", 4'b0010, 1'b0, 1'b0);

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
